control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control unit for the 9-bit-class ISA, generalised in instruction/ALU-op width.
//  Accepts one instruction per fetch handshake and latches it into an internal IR.
//  Walks FETCH/DECODE/EXEC/MEM/WB, driving registered datapath controls per state.
//  Waits on memory acknowledge with a bounded timeout; halts on HALT opcode or timeout.
//  Sits between the instruction fetch unit and the register-file/ALU/data-memory datapath.
// PARAMETERS
//  INSTR_W      9   instruction width; type = instr[INSTR_W-1:INSTR_W-2], r_w = instr[INSTR_W-3]
//  ALU_OP_W     3   ALU op width; ALU-type op field = instr[INSTR_W-3 -: ALU_OP_W]
//  MEM_TIMEOUT  15  max cycles in MEM without mem_ack before error halt (>=1)
// PORTS
//  clk            in   1         clock, rising edge
//  reset          in   1         synchronous, active-high
//  instr_valid    in   1         fetch unit presents instr
//  instr          in   INSTR_W   instruction word
//  instr_ready    out  1         high only in FETCH; transfer on valid&ready
//  branch_taken   in   1         ALU compare result, sampled in EXEC of a branch
//  mem_ack        in   1         data memory completed current read/write
//  pc_en          out  1         1-cycle pulse: PC <= PC+1
//  pc_load        out  1         1-cycle pulse: PC <= branch target
//  branch         out  1         branch instruction in EXEC
//  alu_op         out  ALU_OP_W  ALU operation
//  write_reg      out  1         1-cycle register-file write strobe
//  mem_to_reg     out  1         writeback selects memory data
//  mem_read       out  1         held in MEM for loads until ack
//  mem_write      out  1         held in MEM for stores until ack
//  use_immediate  out  1         operand B = immediate
//  busy           out  1         state != FETCH and != HALT
//  done           out  1         in HALT (HALT opcode retired)
//  error          out  1         in HALT due to memory timeout; sticky until reset
// BEHAVIOUR
//  - Reset (any state, mid-transfer): state=FETCH, IR=0, timeout cnt=0; all outputs 0.
//  - All outputs are registered/state-decoded; no combinational path from inputs to outputs.
//  - FETCH: instr_ready=1; on instr_valid, IR<=instr, go to DECODE; else stay.
//  - DECODE (1 cycle): IR all-ones -> HALT (done=1, no pc_en); otherwise go to EXEC.
//  - EXEC, by type:
//    00 ALU:    alu_op=IR op field; next WB.
//    10 IMM:    alu_op=OP_ADD, use_immediate=1; next WB.
//    01 BRANCH: branch=1, alu_op=OP_CMP; pc_load=branch_taken, pc_en=!branch_taken; next FETCH.
//    11 MEM:    next MEM.
//  - MEM: load (r_w=0): mem_read=1, mem_to_reg=1; store: mem_write=1.
//    Counter increments each cycle in MEM without mem_ack.
//    mem_ack: load -> WB; store -> pc_en pulse, FETCH; counter cleared.
//    Counter reaches MEM_TIMEOUT with no ack -> HALT, error=1; mem_* dropped.
//  - WB: write_reg=1 one cycle, pc_en=1; mem_to_reg held for loads; next FETCH.
//  - Latency from accept (instr_ready back high):
//    ALU/IMM 4 cycles, branch 3, load 4+wait, store 3+wait.
//  - HALT: absorbing; instr_ready=0, done or error held until reset.
//  - mem_ack outside MEM is ignored; branch_taken outside branch EXEC is ignored.
//  - pc_en and pc_load are mutually exclusive every cycle.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined:
//    adds out ports retired_cnt[31:0] (+1 per completed non-HALT instr) and
//    stall_cnt[31:0] (+1 per MEM cycle without ack); both wrap at 2^32, reset to 0.
//  CTRL_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package ctrl_pkg:
//    state_t enum {FETCH,DECODE,EXEC,MEM,WB,HALT};
//    instr_type_t {T_ALU=2'b00,T_BR=2'b01,T_IMM=2'b10,T_MEM=2'b11}; OP_ADD=0, OP_CMP=1.
//  Sub-module ctrl_decode: pure combinational IR -> type/rw/op/is_halt; FSM lives in top.
// TESTING
//  1 ALU 9'b00_011_0000 valid in FETCH -> DECODE,EXEC(alu_op=3),WB(write_reg=1,pc_en=1); ready again 4 cycles after accept.
//  2 Branch 9'b01_0000000, branch_taken=1 in EXEC -> pc_load=1, pc_en=0, branch=1; taken=0 -> pc_en=1 only.
//  3 Load 9'b11_0_000000, mem_ack after 3 cycles -> mem_read high 4 cycles, WB with mem_to_reg=1, write_reg=1.
//  4 Store 9'b11_1_000000, no mem_ack -> after 15 MEM cycles HALT, error=1, mem_write=0, instr_ready stays 0.
//  5 Instr 9'h1FF -> done=1 two cycles after accept, no pc_en; reset high 1 cycle -> FETCH, done=0.
//  6 Reset asserted in MEM during load -> next cycle all outputs 0, instr_ready=1; perf counters (if EN) = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Optional perf counters in the top are enabled with CTRL_PERF_CNT_EN.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        T_ALU = 2'b00,
        T_BR  = 2'b01,
        T_IMM = 2'b10,
        T_MEM = 2'b11
    } instr_type_t;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_CMP = 1;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational field extraction from the latched instruction register.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W  = 9,
    parameter int ALU_OP_W = 3
) (
    input  logic [INSTR_W-1:0]  ir,
    output instr_type_t         itype,
    output logic                rw,
    output logic [ALU_OP_W-1:0] op,
    output logic                is_halt
);

    assign itype   = instr_type_t'(ir[INSTR_W-1 -: 2]);
    assign rw      = ir[INSTR_W-3];
    assign op      = ir[INSTR_W-3 -: ALU_OP_W];
    // The all-ones word doubles as HALT regardless of its type field.
    assign is_halt = &ir;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with registered datapath controls.
// Define CTRL_PERF_CNT_EN to add retired_cnt / stall_cnt performance counters.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int INSTR_W     = 9,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                instr_ready,
    input  logic                branch_taken,
    input  logic                mem_ack,
    output logic                pc_en,
    output logic                pc_load,
    output logic                branch,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                write_reg,
    output logic                mem_to_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                use_immediate,
    output logic                busy,
    output logic                done,
    output logic                error
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t               state_r, next_s;
    logic [INSTR_W-1:0]   ir_r, ir_next_s;
    logic [CNT_W-1:0]     cnt_r, cnt_next_s;

    instr_type_t          dec_type_s;
    logic                 dec_rw_s;
    logic [ALU_OP_W-1:0]  dec_op_s;
    logic                 dec_halt_s;

    logic                 pc_en_s, pc_load_s, done_set_s, err_set_s;
    logic                 branch_d_s, use_imm_d_s, write_reg_d_s;
    logic                 mem_read_d_s, mem_write_d_s, mem_to_reg_d_s, busy_d_s;
    logic [ALU_OP_W-1:0]  alu_op_d_s;

    logic                 instr_ready_r, pc_en_r, pc_load_r, branch_r, write_reg_r;
    logic                 mem_to_reg_r, mem_read_r, mem_write_r, use_imm_r;
    logic                 busy_r, done_r, error_r;
    logic [ALU_OP_W-1:0]  alu_op_r;

    ctrl_decode #(
        .INSTR_W  (INSTR_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .ir      (ir_r),
        .itype   (dec_type_s),
        .rw      (dec_rw_s),
        .op      (dec_op_s),
        .is_halt (dec_halt_s)
    );

    // Next-state, IR capture, MEM timeout counting and input-sampled pulse events.
    always_comb begin
        next_s     = state_r;
        ir_next_s  = ir_r;
        cnt_next_s = {CNT_W{1'b0}};
        pc_en_s    = 1'b0;
        pc_load_s  = 1'b0;
        done_set_s = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            FETCH: begin
                if (instr_valid) begin
                    ir_next_s = instr;
                    next_s    = DECODE;
                end else begin
                    next_s = FETCH;
                end
            end
            DECODE: begin
                if (dec_halt_s) begin
                    next_s     = HALT;
                    done_set_s = 1'b1;
                end else begin
                    next_s = EXEC;
                end
            end
            EXEC: begin
                case (dec_type_s)
                    T_ALU, T_IMM: next_s = WB;
                    T_BR: begin
                        pc_load_s = branch_taken;
                        pc_en_s   = !branch_taken;
                        next_s    = FETCH;
                    end
                    T_MEM:   next_s = MEM;
                    default: next_s = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (dec_rw_s) begin
                        pc_en_s = 1'b1;
                        next_s  = FETCH;
                    end else begin
                        next_s = WB;
                    end
                end else if (cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
                    next_s    = HALT;
                    err_set_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                    next_s     = MEM;
                end
            end
            WB:      next_s = FETCH;
            HALT:    next_s = HALT;
            default: next_s = FETCH;
        endcase
    end

    // Datapath controls decoded from the state being entered, so they register in step with it.
    always_comb begin
        branch_d_s     = 1'b0;
        alu_op_d_s     = {ALU_OP_W{1'b0}};
        use_imm_d_s    = 1'b0;
        mem_read_d_s   = 1'b0;
        mem_write_d_s  = 1'b0;
        mem_to_reg_d_s = 1'b0;
        write_reg_d_s  = 1'b0;
        busy_d_s       = (next_s != FETCH) && (next_s != HALT);
        case (next_s)
            EXEC: begin
                case (dec_type_s)
                    T_ALU: alu_op_d_s = dec_op_s;
                    T_IMM: begin
                        alu_op_d_s  = ALU_OP_W'(OP_ADD);
                        use_imm_d_s = 1'b1;
                    end
                    T_BR: begin
                        alu_op_d_s = ALU_OP_W'(OP_CMP);
                        branch_d_s = 1'b1;
                    end
                    T_MEM:   alu_op_d_s = {ALU_OP_W{1'b0}};
                    default: alu_op_d_s = {ALU_OP_W{1'b0}};
                endcase
            end
            MEM: begin
                if (dec_rw_s) begin
                    mem_write_d_s = 1'b1;
                end else begin
                    mem_read_d_s   = 1'b1;
                    mem_to_reg_d_s = 1'b1;
                end
            end
            WB: begin
                write_reg_d_s = 1'b1;
                if ((dec_type_s == T_MEM) && !dec_rw_s) begin
                    mem_to_reg_d_s = 1'b1;
                end else begin
                    mem_to_reg_d_s = 1'b0;
                end
            end
            default: branch_d_s = 1'b0;
        endcase
    end

    // State, IR, timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH;
            ir_r          <= {INSTR_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            instr_ready_r <= 1'b1;
            pc_en_r       <= 1'b0;
            pc_load_r     <= 1'b0;
            branch_r      <= 1'b0;
            alu_op_r      <= {ALU_OP_W{1'b0}};
            write_reg_r   <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            use_imm_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            state_r       <= next_s;
            ir_r          <= ir_next_s;
            cnt_r         <= cnt_next_s;
            instr_ready_r <= (next_s == FETCH);
            pc_en_r       <= pc_en_s | (next_s == WB);
            pc_load_r     <= pc_load_s;
            branch_r      <= branch_d_s;
            alu_op_r      <= alu_op_d_s;
            write_reg_r   <= write_reg_d_s;
            mem_to_reg_r  <= mem_to_reg_d_s;
            mem_read_r    <= mem_read_d_s;
            mem_write_r   <= mem_write_d_s;
            use_imm_r     <= use_imm_d_s;
            busy_r        <= busy_d_s;
            done_r        <= done_r | done_set_s;
            error_r       <= error_r | err_set_s;
        end
    end

    assign instr_ready   = instr_ready_r;
    assign pc_en         = pc_en_r;
    assign pc_load       = pc_load_r;
    assign branch        = branch_r;
    assign alu_op        = alu_op_r;
    assign write_reg     = write_reg_r;
    assign mem_to_reg    = mem_to_reg_r;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign use_immediate = use_imm_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

`ifdef CTRL_PERF_CNT_EN
    logic        retire_s, stall_s;
    logic [31:0] retired_r, stall_r;

    // Retirement points: WB, branch EXEC, acknowledged store; stalls are un-acked MEM cycles.
    always_comb begin
        retire_s = (state_r == WB) ||
                   ((state_r == EXEC) && (dec_type_s == T_BR)) ||
                   ((state_r == MEM) && mem_ack && dec_rw_s);
        stall_s  = (state_r == MEM) && !mem_ack;
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= 32'd0;
            stall_r   <= 32'd0;
        end else begin
            retired_r <= retired_r + {31'd0, retire_s};
            stall_r   <= stall_r + {31'd0, stall_s};
        end
    end

    assign retired_cnt = retired_r;
    assign stall_cnt   = stall_r;
`endif

endmodule
